modn_cascade_counter: RTL and testbench
=======================================

# modn_cascade_counter

Synchronous, parametrised multi-digit modulo-N counter. DIGITS cascaded digits each count modulo MOD, with up/down, parallel load, enable, saturate mode and a cascade carry. All flops share one clock edge, so there is no ripple delay and no decoded asynchronous clear. It serves as the general counter for decade, timer and BCD display chains; instances cascade through co/en.

## Interface
- DIGITS, 2, number of cascaded digits; must be at least 1.
- MOD, 10, modulus of each digit; 2 ≤ MOD ≤ 2^WIDTH.
- WIDTH, 4, bits per digit.

- clk  input  1  single clock; all state updates on the rising edge.
- clr  input  1  reset, synchronous, active-low.
- en  input  1  count enable.
- up  input  1  direction: 1 counts up, 0 counts down.
- sat  input  1  1 = saturate at the terminal value; 0 = wrap.
- load  input  1  parallel load strobe.
- din  input  DIGITS*WIDTH  load value; digit i occupies bits [i*WIDTH +: WIDTH], digit 0 is least significant.
- q  output  DIGITS*WIDTH  count value, same packing as din.
- co  output  1  cascade carry/borrow; combinational.
- wrap  output  1  registered one-cycle pulse after a rollover.
- load_err  output  1  registered one-cycle flag after a load that contained an illegal digit.

## Operation
- Priority per edge: clr low > load > en > hold.
- Reset (clr=0 at the edge): q=0, wrap=0, load_err=0, regardless of load/en.
- Load (clr=1, load=1): each digit takes its din field. A digit field ≥ MOD loads as 0. load_err=1 for the next cycle if any field was ≥ MOD, else 0. wrap=0. en is ignored.
- Count (clr=1, load=0, en=1):
  - Up: digit 0 increments. Digit i increments only when all lower digits equal MOD-1 and roll to 0.
  - Down: digit 0 decrements. Digit i decrements only when all lower digits equal 0 and roll to MOD-1.
- Terminal value: all digits equal MOD-1 when up=1; all digits equal 0 when up=0.
- At the terminal value with en=1:
  - sat=0: the whole counter wraps (up → all 0; down → all MOD-1), and wrap=1 next cycle.
  - sat=1: q holds and wrap stays 0.
- Hold (en=0, load=0): q unchanged, wrap=0, load_err=0.
- co = en & clr & ~load & (q at the terminal value for the current up). co is asserted in saturate mode as well. Feeding co into the next instance's en extends the chain.
- up may change on any cycle and takes effect at the next edge. Each digit independently follows the up/down rule above.

## Timing
- Count, load and reset latency is 1 cycle: q reflects an action after the edge at which it is sampled.
- co is combinational from en, clr, load, up and q, with 0 cycles of latency. It is valid in the same cycle, so the downstream instance advances on the same edge as this instance wraps.
- wrap and load_err are high for exactly one cycle and low after reset.
- Outputs after reset: q=0, wrap=0, load_err=0. co=0 while clr=0.
- Reset asserted mid-count discards the count at that edge with no partial update. clr=0 together with load=1 resolves to reset.
- load=1 together with en=1 resolves to load only, with no count applied on that edge.
- Unreachable internal digit values (≥ MOD) never occur because load sanitises its input.

## Test plan
- Reset: count to 0x37 (default params), drive clr=0 for one edge with en=1 and load=1 → q=0x00, wrap=0, load_err=0, co=0. Release → the count resumes from 0x00 → 0x01.
- Up wrap: from 0x00 with en=1, up=1, sat=0 for 100 edges → q passes 0x09 → 0x10, 0x99 → 0x00. co=1 only while q=0x99. wrap=1 for exactly the cycle after 0x00 is reached.
- Down wrap and borrow: load 0x01 with up=0 and en=1 → 0x00 (co=1) → 0x99 with wrap pulse → 0x98. A digit borrow 0x10 → 0x09 occurs.
- Load handling:
  - din=0x57 with load=1, en=1 → q=0x57 with no increment. Next edge (en=1, up=1) → 0x58.
  - din=0xA3 → q=0x03, load_err=1 for one cycle.
- Saturate: sat=1, up=1 from 0x98 → 0x99, then holds at 0x99 for 5 edges with co=1 and wrap=0. Switching up=0 → 0x98.
- Parametric: DIGITS=3, MOD=6, WIDTH=3, count up from 0 → the digit sequence runs 0..5 per digit and the counter wraps to 0 after 216 edges. Two instances chained via co→en count 0..(6^6)-1 consistently.

Source files
------------

// File: rtl/modn_cascade_counter_if.sv
// Control and data bundle for one modn_cascade_counter instance.
// The counter itself connects through the slave modport; the driver uses master.
interface modn_cascade_counter_if #(
  parameter int DIGITS = 2,
  parameter int WIDTH  = 4
);
  logic                      en;
  logic                      up;
  logic                      sat;
  logic                      load;
  logic [DIGITS*WIDTH-1:0]   din;
  logic [DIGITS*WIDTH-1:0]   q;
  logic                      co;
  logic                      wrap;
  logic                      load_err;

  modport master (output en, up, sat, load, din, input q, co, wrap, load_err);
  modport slave  (input en, up, sat, load, din, output q, co, wrap, load_err);
endinterface

// File: rtl/modn_cascade_counter.sv
// Synchronous DIGITS-digit modulo-MOD up/down counter with load, saturate and
// a combinational cascade carry; every digit updates on the same clock edge.
module modn_cascade_counter #(
  parameter int DIGITS = 2,
  parameter int MOD    = 10,
  parameter int WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  modn_cascade_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] DMAX = WIDTH'(MOD - 1);

  typedef logic [DIGITS-1:0][WIDTH-1:0] digits_t;

  digits_t           q_q, q_d, din_v, din_ok, step_v;
  logic              wrap_q, wrap_d;
  logic              load_err_q, load_err_d;
  logic [DIGITS:0]   lo_max, lo_zero;
  logic [DIGITS-1:0] bad;
  logic              term;

  assign din_v = bus.din;

  // lo_max[i]/lo_zero[i]: every digit below i sits at MOD-1 / 0.
  always_comb begin
    lo_max     = '0;
    lo_zero    = '0;
    bad        = '0;
    din_ok     = '0;
    lo_max[0]  = 1'b1;
    lo_zero[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      lo_max[i+1]  = lo_max[i]  && (q_q[i] == DMAX);
      lo_zero[i+1] = lo_zero[i] && (q_q[i] == '0);
      bad[i]       = din_v[i] > DMAX;
      din_ok[i]    = bad[i] ? '0 : din_v[i];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    always_comb begin
      step_v[i] = q_q[i];
      if (bus.up) begin
        if (lo_max[i])
          step_v[i] = (q_q[i] == DMAX) ? '0 : q_q[i] + WIDTH'(1);
      end else begin
        if (lo_zero[i])
          step_v[i] = (q_q[i] == '0) ? DMAX : q_q[i] - WIDTH'(1);
      end
    end
  end

  assign term = bus.up ? lo_max[DIGITS] : lo_zero[DIGITS];

  always_comb begin
    q_d        = q_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      q_d        = din_ok;
      load_err_d = |bad;
    end else if (bus.en && !(term && bus.sat)) begin
      // At the terminal value the per-digit rule already rolls every digit.
      q_d    = step_v;
      wrap_d = term;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;
  assign bus.co       = bus.en & clr & ~bus.load & term;
endmodule

// File: tb/tb_modn_cascade_counter.sv
// Directed bench: BCD vector table, multi-cycle wrap/borrow/saturate runs and
// a two-instance base-6 chain linked through co -> en.
module tb_modn_cascade_counter;
  logic clk = 1'b0;
  logic clr;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  modn_cascade_counter_if #(.DIGITS(2), .WIDTH(4)) bi ();
  modn_cascade_counter_if #(.DIGITS(3), .WIDTH(3)) ci0 ();
  modn_cascade_counter_if #(.DIGITS(3), .WIDTH(3)) ci1 ();

  modn_cascade_counter #(.DIGITS(2), .MOD(10), .WIDTH(4)) dut (.clk(clk), .clr(clr), .bus(bi));
  modn_cascade_counter #(.DIGITS(3), .MOD(6), .WIDTH(3)) c0 (.clk(clk), .clr(clr), .bus(ci0));
  modn_cascade_counter #(.DIGITS(3), .MOD(6), .WIDTH(3)) c1 (.clk(clk), .clr(clr), .bus(ci1));

  assign ci1.en = ci0.co;

  typedef struct {
    logic       clr, load, en, up, sat;
    logic [7:0] din;
    logic       co;
    logic [7:0] q;
    logic       wrap, lerr;
  } vec_t;

  vec_t tv[28];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [17:0] b6(input int v);
    logic [17:0] r;
    int c;
    r = '0;
    c = v;
    for (int i = 0; i < 6; i++) begin
      r[i*3 +: 3] = 3'(c % 6);
      c = c / 6;
    end
    return r;
  endfunction

  task automatic drive(input logic ld, input logic e, input logic u, input logic s, input logic [7:0] d);
    bi.load = ld; bi.en = e; bi.up = u; bi.sat = s; bi.din = d;
  endtask

  initial begin
    int v, cnt;
    //            clr ld en up sat din    co  q     w  e
    tv[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,8'h00,1'b0,1'b0};
    tv[1]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,8'h57, 1'b0,8'h57,1'b0,1'b0};
    tv[2]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,8'h58,1'b0,1'b0};
    tv[3]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,8'hA3, 1'b0,8'h03,1'b0,1'b1};
    tv[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,8'h03,1'b0,1'b0};
    tv[5]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,8'h99, 1'b0,8'h99,1'b0,1'b0};
    tv[6]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,8'h00,1'b1,1'b0};
    tv[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,8'h00,1'b0,1'b0};
    tv[8]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'h00, 1'b1,8'h99,1'b1,1'b0};
    tv[9]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h98,1'b0,1'b0};
    tv[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,8'h10, 1'b0,8'h10,1'b0,1'b0};
    tv[11] = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h09,1'b0,1'b0};
    tv[12] = '{1'b1,1'b1,1'b0,1'b1,1'b0,8'hFF, 1'b0,8'h00,1'b0,1'b1};
    tv[13] = '{1'b1,1'b1,1'b1,1'b1,1'b0,8'h9B, 1'b0,8'h90,1'b0,1'b1};
    tv[14] = '{1'b1,1'b1,1'b1,1'b1,1'b0,8'h37, 1'b0,8'h37,1'b0,1'b0};
    tv[15] = '{1'b0,1'b1,1'b1,1'b1,1'b0,8'h55, 1'b0,8'h00,1'b0,1'b0};
    tv[16] = '{1'b1,1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,8'h01,1'b0,1'b0};
    tv[17] = '{1'b1,1'b1,1'b0,1'b1,1'b1,8'h98, 1'b0,8'h98,1'b0,1'b0};
    tv[18] = '{1'b1,1'b0,1'b1,1'b1,1'b1,8'h00, 1'b0,8'h99,1'b0,1'b0};
    tv[19] = '{1'b1,1'b0,1'b1,1'b1,1'b1,8'h00, 1'b1,8'h99,1'b0,1'b0};
    tv[20] = '{1'b1,1'b0,1'b1,1'b0,1'b1,8'h00, 1'b0,8'h98,1'b0,1'b0};
    tv[21] = '{1'b1,1'b1,1'b0,1'b0,1'b1,8'h00, 1'b0,8'h00,1'b0,1'b0};
    tv[22] = '{1'b1,1'b0,1'b1,1'b0,1'b1,8'h00, 1'b1,8'h00,1'b0,1'b0};
    tv[23] = '{1'b1,1'b1,1'b0,1'b1,1'b0,8'h99, 1'b0,8'h99,1'b0,1'b0};
    tv[24] = '{1'b1,1'b0,1'b1,1'b1,1'b0,8'h00, 1'b1,8'h00,1'b1,1'b0};
    tv[25] = '{1'b0,1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,8'h00,1'b0,1'b0};
    tv[26] = '{1'b1,1'b1,1'b0,1'b1,1'b0,8'hA0, 1'b0,8'h00,1'b0,1'b1};
    tv[27] = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,8'h00,1'b0,1'b0};

    clr = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    ci0.en = 1'b0; ci0.up = 1'b1; ci0.sat = 1'b0; ci0.load = 1'b0; ci0.din = '0;
    ci1.up = 1'b1; ci1.sat = 1'b0; ci1.load = 1'b0; ci1.din = '0;
    tick(); tick();
    check("rst_q", 32'(bi.q), 32'h00);
    check("rst_wrap", 32'(bi.wrap), 32'h0);
    check("rst_lerr", 32'(bi.load_err), 32'h0);
    check("rst_co", 32'(bi.co), 32'h0);
    check("rst_chain_q", 32'({ci1.q, ci0.q}), 32'h0);
    clr = 1'b1;

    // Vector table
    foreach (tv[i]) begin
      clr = tv[i].clr;
      drive(tv[i].load, tv[i].en, tv[i].up, tv[i].sat, tv[i].din);
      #1;
      check($sformatf("vec%0d_co", i), 32'(bi.co), 32'(tv[i].co));
      tick();
      check($sformatf("vec%0d_q", i), 32'(bi.q), 32'(tv[i].q));
      check($sformatf("vec%0d_wrap", i), 32'(bi.wrap), 32'(tv[i].wrap));
      check($sformatf("vec%0d_lerr", i), 32'(bi.load_err), 32'(tv[i].lerr));
    end
    clr = 1'b1;

    // Reset mid-count with load and en asserted
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    repeat (37) tick();
    check("cnt_to_37", 32'(bi.q), 32'h37);
    clr = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h99);
    #1;
    check("midrst_co", 32'(bi.co), 32'h0);
    tick();
    check("midrst_q", 32'(bi.q), 32'h00);
    check("midrst_wrap", 32'(bi.wrap), 32'h0);
    check("midrst_lerr", 32'(bi.load_err), 32'h0);
    clr = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    check("resume_q", 32'(bi.q), 32'h01);

    // Up wrap across 100 edges
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    #1;
    v = 0;
    for (int k = 0; k < 100; k++) begin
      check($sformatf("up%0d_co", k), 32'(bi.co), 32'(v == 99));
      tick();
      check($sformatf("up%0d_wrap", k), 32'(bi.wrap), 32'(v == 99));
      v = (v + 1) % 100;
      check($sformatf("up%0d_q", k), 32'(bi.q), 32'(bcd(v)));
    end

    // Down wrap and borrow
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h01); tick();
    check("dn_load_q", 32'(bi.q), 32'h01);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    #1;
    check("dn01_co", 32'(bi.co), 32'h0);
    tick();
    check("dn00_q", 32'(bi.q), 32'h00);
    check("dn00_co", 32'(bi.co), 32'h1);
    tick();
    check("dn99_q", 32'(bi.q), 32'h99);
    check("dn99_wrap", 32'(bi.wrap), 32'h1);
    tick();
    check("dn98_q", 32'(bi.q), 32'h98);
    check("dn98_wrap", 32'(bi.wrap), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h12); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    v = 12;
    for (int k = 0; k < 5; k++) begin
      tick();
      v = v - 1;
      check($sformatf("borrow%0d_q", k), 32'(bi.q), 32'(bcd(v)));
    end

    // Saturate hold, then reverse direction
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h98); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h00); tick();
    check("sat_q99", 32'(bi.q), 32'h99);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("sat%0d_co", k), 32'(bi.co), 32'h1);
      tick();
      check($sformatf("sat%0d_q", k), 32'(bi.q), 32'h99);
      check($sformatf("sat%0d_wrap", k), 32'(bi.wrap), 32'h0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00); tick();
    check("sat_rev_q", 32'(bi.q), 32'h98);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

    // Two base-6 instances chained: full 6^6 cycle
    ci0.en = 1'b1;
    #1;
    cnt = 0;
    for (int k = 0; k < 46656; k++) begin
      tick();
      cnt = (cnt + 1) % 46656;
      check("chain_q", 32'({ci1.q, ci0.q}), 32'(b6(cnt)));
      check("chain_wrap0", 32'(ci0.wrap), 32'((cnt % 216) == 0));
      check("chain_wrap1", 32'(ci1.wrap), 32'(cnt == 0));
      if (n_bad > 20) break;
    end
    check("chain_end_q", 32'({ci1.q, ci0.q}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
